rtc_spi_bridge: RTL and testbench

SPI-mode-0 target that lets an external host read and write the RTC register file. It decodes 16-bit serial frames (command byte + data byte), drives the register file's `addr`, `data_in`, `write_en` and `read_en` ports, and shifts read data back on MISO. It sits between the chip pins and the 16×8 register file. All SPI inputs are oversampled and synchronized to `clk`.

---
 rtl/rtc_pkg.sv | 14 +
 rtl/sync_edge_det.sv | 35 +++
 rtl/rtc_spi_bridge.sv | 149 ++++++++++++++
 tb/tb_rtc_spi_bridge.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared frame constants and FSM encoding for the RTC SPI bridge.
package rtc_pkg;
  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS   = FRAME_BITS / 2;
  localparam int RW_READ    = 15;
  localparam int CMD_RW_BIT = RW_READ - CMD_BITS;
  localparam int RTC_ADDR_W = 4;
  localparam int RTC_DATA_W = 8;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_FETCH, ST_LOAD, ST_DATA, ST_COMMIT, ST_DONE
  } rtc_state_t;
endpackage

// File: rtl/sync_edge_det.sv
// N-stage synchronizer with single-cycle rise/fall pulses on the synchronized level.
module sync_edge_det #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic              last;
  logic [STAGES:0]   vld_pipe;

  // Edges stay masked until the chain and the history flop hold real samples,
  // so a level held across reset never looks like a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain    <= {STAGES{RST_VAL}};
      last     <= RST_VAL;
      vld_pipe <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      last     <= chain[STAGES-1];
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = vld_pipe[STAGES] &  q & ~last;
  assign fall = vld_pipe[STAGES] & ~q &  last;
endmodule

// File: rtl/rtc_spi_bridge.sv
// SPI mode-0 target translating 16-bit command/data frames into register-file
// read and write strobes; read data returns on MISO during the data byte.
module rtc_spi_bridge import rtc_pkg::*; #(
  parameter int ADDR_W      = RTC_ADDR_W,  // must be <= 7
  parameter int DATA_W      = RTC_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_write_en,
  output logic              rf_read_en,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy,
  output logic              frame_err
);
  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic mosi_q;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .d(spi_sclk),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .d(spi_cs_n),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  // One stage deeper than the edge path would be late; same depth keeps MOSI
  // aligned with the detected sclk rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_chain <= '0;
    end else begin
      mosi_chain[0] <= spi_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) mosi_chain[i] <= mosi_chain[i-1];
    end
  end
  assign mosi_q = mosi_chain[SYNC_STAGES-1];

  rtc_state_t             state;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [DATA_W-2:0]      rx_sr;
  logic [DATA_W-1:0]      rx_next;
  logic [DATA_W-1:0]      tx_sr;
  logic                   is_read;
  logic                   cmd_edge, last_edge, abort;

  assign rx_next   = {rx_sr, mosi_q};
  assign cmd_edge  = sclk_rise && (bit_cnt == BIT_CNT_W'(CMD_BITS - 1));
  assign last_edge = sclk_rise && (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
  // A CS release coinciding with the 16th edge completes the frame rather than aborting it.
  assign abort     = cs_rise && (state inside {ST_CMD, ST_FETCH, ST_LOAD, ST_DATA})
                     && !(state == ST_DATA && last_edge);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      is_read     <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      rf_addr     <= '0;
      rf_wdata    <= '0;
      rf_write_en <= 1'b0;
      rf_read_en  <= 1'b0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rf_write_en <= 1'b0;
      rf_read_en  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= ~cs_q;
      if (abort) begin
        state       <= ST_IDLE;
        frame_err   <= 1'b1;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            // Mode 0: a frame only starts with sclk parked low.
            if (cs_fall && !sclk_q) begin
              state   <= ST_CMD;
              bit_cnt <= '0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              rx_sr   <= rx_next[DATA_W-2:0];
              bit_cnt <= bit_cnt + 1'b1;
            end
            if (cmd_edge) begin
              rf_addr <= rx_next[ADDR_W-1:0];
              is_read <= rx_next[CMD_RW_BIT];
              if (rx_next[CMD_RW_BIT]) begin
                state      <= ST_FETCH;
                rf_read_en <= 1'b1;
              end else begin
                state <= ST_DATA;
              end
            end
          end
          ST_FETCH: state <= ST_LOAD;
          ST_LOAD: begin
            tx_sr       <= rf_rdata;
            spi_miso_oe <= 1'b1;
            state       <= ST_DATA;
          end
          ST_DATA: begin
            if (last_edge) begin
              spi_miso_oe <= 1'b0;
              if (is_read) begin
                state <= ST_DONE;
              end else begin
                rf_wdata    <= rx_next;
                rf_write_en <= 1'b1;
                state       <= ST_COMMIT;
              end
            end else if (sclk_rise) begin
              rx_sr   <= rx_next[DATA_W-2:0];
              bit_cnt <= bit_cnt + 1'b1;
            end
            if (sclk_fall && is_read) begin
              spi_miso <= tx_sr[DATA_W-1];
              tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
            end
          end
          ST_COMMIT: state <= ST_DONE;
          ST_DONE:   if (cs_q) state <= ST_IDLE;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rtc_spi_bridge.sv
// Randomized self-checking bench: SPI host driver, register-file stand-in and a
// frame-level reference memory.
module tb_rtc_spi_bridge;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_sclk, spi_cs_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [3:0] rf_addr;
  logic [7:0] rf_wdata;
  logic       rf_write_en, rf_read_en;
  logic [7:0] rf_rdata = 8'h00;
  logic       busy, frame_err;

  rtc_spi_bridge #(.ADDR_W(4), .DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_write_en(rf_write_en),
    .rf_read_en(rf_read_en), .rf_rdata(rf_rdata), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Register file stand-in: the environment the bridge drives.
  logic [7:0] env_mem [16];
  always @(posedge clk) begin
    if (rf_read_en)  rf_rdata <= env_mem[rf_addr];
    if (rf_write_en) env_mem[rf_addr] <= rf_wdata;
  end

  // Strobe monitor.
  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, overlap = 0;
  logic [3:0] last_waddr = 0, last_raddr = 0;
  logic [7:0] last_wdata = 0;
  always @(negedge clk) begin
    if (rf_write_en) begin wr_cnt++; last_waddr = rf_addr; last_wdata = rf_wdata; end
    if (rf_read_en)  begin rd_cnt++; last_raddr = rf_addr; end
    if (frame_err) err_cnt++;
    if (rf_write_en && rf_read_en) overlap++;
  end

  int n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: what the register file holds after each completed frame.
  logic [7:0] ref_mem [16];

  // Drives one frame; npulses sclk pulses (bits past 16 are random), optional
  // reset pulse before pulse rst_at. Returns MISO byte, oe per bit, busy mid-frame.
  task automatic spi_frame(input logic [15:0] f, input int npulses, input int rst_at,
                           output logic [7:0] rd, output logic [15:0] oe_bits,
                           output logic bsy);
    rd = 0; oe_bits = 0; bsy = 0;
    spi_cs_n = 1'b0;
    wclk(HALF);
    for (int i = 0; i < npulses; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        wclk(2);
        @(negedge clk);
        chk("reset_mid_frame", {spi_miso, spi_miso_oe, rf_write_en, rf_read_en, busy,
                                frame_err, rf_addr, rf_wdata}, 0);
        rst_n = 1'b1;
        wclk(HALF);
        break;
      end
      spi_mosi = (i < 16) ? f[15-i] : 1'($urandom_range(1, 0));
      wclk(HALF);
      #1;
      if (i == 0) bsy = busy;
      if (i < 16) begin
        oe_bits[15-i] = spi_miso_oe;
        if (i >= 8) rd[15-i] = spi_miso;
      end
      spi_sclk = 1'b1;
      wclk(HALF);
      spi_sclk = 1'b0;
    end
    wclk(HALF);
    spi_cs_n = 1'b1;
    wclk(4 * HALF);
  endtask

  logic [7:0]  rd;
  logic [15:0] oe;
  logic        bsy;
  int w0, r0, e0;

  task automatic snap();
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
  endtask

  task automatic do_write(input string tag, input logic [3:0] a, input logic [7:0] d,
                          input int np);
    snap();
    spi_frame({1'b0, 3'($urandom_range(7, 0)), a, d}, np, -1, rd, oe, bsy);
    ref_mem[a] = d;
    chk({tag, "_wr"}, wr_cnt - w0, 1);
    chk({tag, "_waddr"}, last_waddr, a);
    chk({tag, "_wdata"}, last_wdata, ref_mem[a]);
    chk({tag, "_err"}, err_cnt - e0, 0);
  endtask

  task automatic do_read(input string tag, input logic [3:0] a);
    snap();
    spi_frame({1'b1, 3'($urandom_range(7, 0)), a, 8'($urandom)}, 16, -1, rd, oe, bsy);
    chk({tag, "_rd"}, rd_cnt - r0, 1);
    chk({tag, "_raddr"}, last_raddr, a);
    chk({tag, "_miso"}, rd, ref_mem[a]);
    chk({tag, "_oe"}, oe, 16'h00FF);
    chk({tag, "_nowr"}, wr_cnt - w0, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin env_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    rst_n = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    wclk(5);
    @(negedge clk);
    chk("reset_outs", {spi_miso, spi_miso_oe, rf_write_en, rf_read_en, busy, frame_err,
                       rf_addr, rf_wdata}, 0);
    rst_n = 1'b1;
    wclk(10);

    // Single write, addr 3 data 0x19.
    snap();
    spi_frame(16'h0319, 16, -1, rd, oe, bsy);
    ref_mem[3] = 8'h19;
    chk("w3_wr", wr_cnt - w0, 1);
    chk("w3_addr", last_waddr, 4'd3);
    chk("w3_data", last_wdata, 8'h19);
    chk("w3_err", err_cnt - e0, 0);
    chk("w3_busy_mid", bsy, 1'b1);
    chk("w3_oe", oe, 16'h0000);
    chk("w3_addr_held", rf_addr, 4'd3);
    chk("busy_idle", busy, 1'b0);

    // Write then read back address 0.
    do_write("w0", 4'd0, 8'h0A, 16);
    do_read("r0", 4'd0);

    // Back-to-back writes then reads.
    for (int i = 0; i < 5; i++) do_write("bb_w", 4'(i), 8'(10 + 5 * i), 16);
    for (int i = 0; i < 5; i++) do_read("bb_r", 4'(i));

    // Abort after 12 bits of a write.
    snap();
    spi_frame(16'h0755, 12, -1, rd, oe, bsy);
    chk("abort_nowr", wr_cnt - w0, 0);
    chk("abort_err", err_cnt - e0, 1);
    do_write("post_abort", 4'd7, 8'hC3, 16);

    // 20 pulses: only the first 16 bits count.
    do_write("extra", 4'd2, 8'h5A, 20);
    do_read("extra_r", 4'd2);

    // Reset during the data byte of a write to addr 5.
    do_write("pre_rst", 4'd5, 8'h77, 16);
    snap();
    spi_frame(16'h0533, 12, 11, rd, oe, bsy);
    chk("rst_nowr", wr_cnt - w0, 0);
    chk("rst_noerr", err_cnt - e0, 0);
    do_read("post_rst", 4'd5);

    // Randomized frames.
    for (int t = 0; t < 30; t++) begin
      logic        rw, ab;
      logic [3:0]  a;
      logic [7:0]  d;
      int          np;
      rw = 1'($urandom_range(1, 0));
      a  = 4'($urandom_range(15, 0));
      d  = 8'($urandom);
      ab = ($urandom_range(4, 0) == 0);
      np = ab ? int'($urandom_range(15, 1)) : 16 + int'($urandom_range(4, 0));
      snap();
      spi_frame({rw, 3'($urandom_range(7, 0)), a, d}, np, -1, rd, oe, bsy);
      chk("rnd_wr", wr_cnt - w0, (!rw && !ab) ? 1 : 0);
      chk("rnd_rd", rd_cnt - r0, (rw && np >= 8) ? 1 : 0);
      chk("rnd_err", err_cnt - e0, ab ? 1 : 0);
      if (!rw && !ab) begin
        ref_mem[a] = d;
        chk("rnd_waddr", last_waddr, a);
        chk("rnd_wdata", last_wdata, d);
      end
      if (rw && !ab) begin
        chk("rnd_miso", rd, ref_mem[a]);
        chk("rnd_oe", oe, 16'h00FF);
      end
    end

    chk("strobe_overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
